// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit for the RISC-V M extension (one bit per cycle).
// Optional macro MULDIV_EARLY_OUT_EN: multiplies finish once the remaining multiplier bits are zero.
module muldiv_unit #(
    parameter int XLEN  = 64,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            ready,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY_OUT = 1'b1;
`else
    localparam bit EARLY_OUT = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    localparam logic [2:0]       OP_MUL    = 3'd0;
    localparam logic [2:0]       OP_MULH   = 3'd1;
    localparam logic [2:0]       OP_MULHSU = 3'd2;
    localparam logic [CNT_W-1:0] CNT_INIT  = CNT_W'(XLEN);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [XLEN-1:0]  ALL_ONES  = '1;
    localparam logic [XLEN-1:0]  MOST_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [2:0]            op_q, op_d;
    logic                  neg_q, neg_d;
    logic [2*XLEN-1:0]     acc_q, acc_d;     // product accumulator / remainder (low half)
    logic [2*XLEN-1:0]     a_q, a_d;         // shifted multiplicand / dividend->quotient (low half)
    logic [XLEN-1:0]       b_q, b_d;         // multiplier (shifts right) / divisor
    logic [XLEN-1:0]       result_q, result_d;

    // Operand decode at accept time
    logic                  in_div, in_s1, in_s2, neg1, neg2, neg_in;
    logic                  div_zero, div_ovf;
    logic [XLEN-1:0]       mag1, mag2;

    always_comb begin
        in_div   = op[2];
        in_s1    = (op == OP_MULH) || (op == OP_MULHSU) || (in_div && !op[0]);
        in_s2    = (op == OP_MULH) || (in_div && !op[0]);
        neg1     = in_s1 && rs1[XLEN-1];
        neg2     = in_s2 && rs2[XLEN-1];
        mag1     = neg1 ? -rs1 : rs1;
        mag2     = neg2 ? -rs2 : rs2;
        // Remainder takes the dividend's sign; product and quotient take the XOR.
        neg_in   = (in_div && op[1]) ? neg1 : (neg1 ^ neg2);
        div_zero = in_div && (rs2 == '0);
        div_ovf  = in_div && !op[0] && (rs1 == MOST_NEG) && (rs2 == ALL_ONES);
    end

    // One iteration of shift-add multiply or restoring divide
    logic [XLEN:0]         shifted, rem_full;
    logic [XLEN+1:0]       diff;
    logic [2*XLEN-1:0]     acc_nx, a_nx, prod;
    logic [XLEN-1:0]       b_nx, quo, remd, fin_res;
    logic                  last;

    always_comb begin
        shifted  = {acc_q[XLEN-1:0], a_q[XLEN-1]};
        diff     = {1'b0, shifted} - {2'b00, b_q};
        rem_full = shifted;
        if (op_q[2]) begin
            rem_full = diff[XLEN+1] ? shifted : diff[XLEN:0];
            acc_nx   = {{(XLEN-1){1'b0}}, rem_full};
            a_nx     = {{XLEN{1'b0}}, a_q[XLEN-2:0], ~diff[XLEN+1]};
            b_nx     = b_q;
        end else begin
            acc_nx   = acc_q + (b_q[0] ? a_q : '0);
            a_nx     = {a_q[2*XLEN-2:0], 1'b0};
            b_nx     = {1'b0, b_q[XLEN-1:1]};
        end

        prod = neg_q ? -acc_nx : acc_nx;
        quo  = a_nx[XLEN-1:0];
        remd = acc_nx[XLEN-1:0];
        if (op_q[2]) begin
            if (op_q[1]) fin_res = neg_q ? -remd : remd;
            else         fin_res = neg_q ? -quo : quo;
        end else begin
            fin_res = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end

        last = (cnt_q == CNT_ONE) || (EARLY_OUT && !op_q[2] && (b_nx == '0));
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    op_d  = op;
                    neg_d = neg_in;
                    cnt_d = CNT_INIT;
                    acc_d = '0;
                    a_d   = {{XLEN{1'b0}}, mag1};
                    b_d   = mag2;
                    if (div_zero) begin
                        state_d  = S_DONE;
                        result_d = op[1] ? rs1 : ALL_ONES;
                    end else if (div_ovf) begin
                        state_d  = S_DONE;
                        result_d = op[1] ? '0 : rs1;
                    end else if (EARLY_OUT && !op[2] && (mag2 == '0)) begin
                        state_d  = S_DONE;
                        result_d = '0;
                    end else begin
                        state_d  = S_CALC;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                acc_d = acc_nx;
                a_d   = a_nx;
                b_d   = b_nx;
                cnt_d = cnt_q - CNT_ONE;
                if (last) begin
                    state_d  = S_DONE;
                    result_d = fin_res;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
        end
    end

    assign ready  = (state_q == S_IDLE) || (state_q == S_DONE);
    assign busy   = (state_q == S_CALC);
    assign done   = (state_q == S_DONE);
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: driver queues expected result and done cycle, monitor checks on done.
module tb_muldiv_unit;
    localparam int XLEN = 64;
    localparam logic [63:0] M1       = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MOST_NEG = 64'h8000_0000_0000_0000;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic [2:0]      op = 3'd0;
    logic [XLEN-1:0] rs1 = '0;
    logic [XLEN-1:0] rs2 = '0;
    logic            ready, busy, done;
    logic [XLEN-1:0] result;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
        .ready(ready), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] res;
        int          cyc;
        int          id;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   txn_id = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_done cycle=%0d got result=%h want no done", cyc, result);
            end else begin
                e = exp_q.pop_front();
                total += 2;
                if (result !== e.res) begin
                    bad++;
                    $display("FAIL txn%0d_result got=%h want=%h", e.id, result, e.res);
                end else
                    $display("txn%0d result=%h cycle=%0d", e.id, result, cyc);
                if (cyc != e.cyc) begin
                    bad++;
                    $display("FAIL txn%0d_latency done_cycle got=%0d want=%0d", e.id, cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic int mul_lat(input logic [63:0] b, input bit s2);
`ifdef MULDIV_EARLY_OUT_EN
        logic [63:0] m;
        m = (s2 && b[63]) ? -b : b;
        for (int i = 63; i >= 0; i--)
            if (m[i]) return i + 2;
        return 1;
`else
        if (s2 && b[63]) return XLEN + 1;
        return XLEN + 1;
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end else
            $display("%s ok value=%h", name, got);
    endtask

    // Called at a negedge; waits for ready, drives one accept cycle, queues the expectation.
    task automatic issue(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] want, input int lat);
        int waited;
        exp_t x;
        waited = 0;
        while (ready !== 1'b1 && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (ready !== 1'b1) begin
            total++; bad++;
            $display("FAIL ready_timeout op=%0d got ready=%b want 1", o, ready);
        end else begin
            txn_id++;
            x.res = want; x.cyc = cyc + lat; x.id = txn_id;
            exp_q.push_back(x);
            start = 1'b1; op = o; rs1 = a; rs2 = b;
            $display("issue txn%0d op=%0d rs1=%h rs2=%h cycle=%0d", txn_id, o, a, b, cyc);
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    // Hammer start/operands while busy; the unit must ignore all of it.
    task automatic disturb(input int n);
        for (int k = 0; k < n; k++) begin
            if (busy !== 1'b1) break;
            start = 1'b1;
            op    = 3'($urandom_range(0, 7));
            rs1   = {$urandom, $urandom};
            rs2   = {$urandom, $urandom};
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        if (exp_q.size() != 0) begin
            total++; bad++;
            $display("FAIL drain_timeout got pending=%0d want 0", exp_q.size());
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_result", result, 64'd0);

        issue(3'd0, 64'd7, 64'd6, 64'd42, mul_lat(64'd6, 1'b0));
        disturb(10);
        drain();
        @(negedge clk);
        check("hold_result", result, 64'd42);
        check("hold_ready", 64'(ready), 64'd1);

        issue(3'd0, 64'd11, 64'd4, 64'd44, mul_lat(64'd4, 1'b0));
        disturb(10);
        issue(3'd0, 64'd3, 64'd3, 64'd9, mul_lat(64'd3, 1'b0));
        disturb(10);
        issue(3'd1, M1, 64'd2, M1, mul_lat(64'd2, 1'b1));
        issue(3'd3, M1, 64'd2, 64'd1, mul_lat(64'd2, 1'b0));
        issue(3'd2, 64'd2, M1, 64'd1, mul_lat(M1, 1'b0));
        issue(3'd4, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, XLEN + 1);
        disturb(10);
        issue(3'd6, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, XLEN + 1);
        issue(3'd7, 64'd20, 64'd3, 64'd2, XLEN + 1);
        issue(3'd5, 64'd5, 64'd0, M1, 1);
        issue(3'd6, 64'd7, 64'd0, 64'd7, 1);
        issue(3'd4, MOST_NEG, M1, MOST_NEG, 1);
        issue(3'd6, MOST_NEG, M1, 64'd0, 1);
        drain();

        // Abort a divide partway through with reset
        issue(3'd5, 64'd100, 64'd7, 64'd14, XLEN + 1);
        repeat (28) @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        check("abort_ready", 64'(ready), 64'd1);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_result", result, 64'd0);
        repeat (40) @(negedge clk);

        issue(3'd0, 64'd5, 64'd3, 64'd15, mul_lat(64'd3, 1'b0));
        drain();
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
